score_run_controller: RTL and testbench



---
 rtl/score_run_controller_pkg.sv | 15 +
 rtl/score_run_controller_bcd4_counter.sv | 45 ++++
 rtl/score_run_controller.sv | 154 +++++++++++++++
 tb/tb_score_run_controller.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/score_run_controller_pkg.sv
// Shared encodings and widths for the game-flow controller and its delegates.
package score_run_controller_pkg;

    localparam int unsigned BcdDigitW = 4;
    localparam int unsigned ScoreW    = 16;
    localparam int unsigned NumDigits = ScoreW / BcdDigitW;

    // Encodings are shared with the score display and obstacle logic; do not renumber.
    typedef enum logic [1:0] {
        GsIdle = 2'b00,
        GsDead = 2'b01,
        GsRun  = 2'b10
    } game_state_e;

endpackage

// File: rtl/score_run_controller_bcd4_counter.sv
// Four-digit BCD up-counter with synchronous clear; 9999 wraps to 0000.
module bcd4_counter
    import score_run_controller_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clr_i,
    input  logic              inc_i,
    output logic [ScoreW-1:0] count_o
);

    logic [ScoreW-1:0] count_d, count_q;
    logic              carry;

    // Ripple the increment through the digits; clear wins over increment.
    always_comb begin
        count_d = count_q;
        carry   = inc_i;
        for (int i = 0; i < int'(NumDigits); i++) begin
            if (carry) begin
                if (count_q[i*BcdDigitW +: BcdDigitW] == 4'd9) begin
                    count_d[i*BcdDigitW +: BcdDigitW] = 4'd0;
                end else begin
                    count_d[i*BcdDigitW +: BcdDigitW] = count_q[i*BcdDigitW +: BcdDigitW] + 4'd1;
                    carry = 1'b0;
                end
            end
        end
        if (clr_i) begin
            count_d = '0;
        end
    end

    // Count register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/score_run_controller.sv
// Game-flow controller: idle/run/game-over sequencing, score ticks, high score, speed level.
module score_run_controller
    import score_run_controller_pkg::*;
#(
    parameter int unsigned TICKS_PER_POINT  = 6,
    parameter int unsigned POINTS_PER_LEVEL = 100,
    parameter int unsigned MAX_LEVEL        = 7,
    parameter int unsigned DEAD_HOLD        = 60
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              frame_tick,
    input  logic              start_btn,
    input  logic              collision,
    output logic [1:0]        gameState,
    output logic              score_tick,
    output logic [ScoreW-1:0] score_bcd,
    output logic [ScoreW-1:0] hi_bcd,
    output logic [2:0]        speed_level,
    output logic              new_hi
);

    localparam int unsigned FrameW = $clog2(TICKS_PER_POINT + 1);
    localparam int unsigned LvlW   = $clog2(POINTS_PER_LEVEL + 1);
    localparam int unsigned HoldW  = $clog2(DEAD_HOLD + 1);

    localparam logic [FrameW-1:0] FrameLast = FrameW'(TICKS_PER_POINT - 1);
    localparam logic [LvlW-1:0]   LvlLast   = LvlW'(POINTS_PER_LEVEL - 1);
    localparam logic [HoldW-1:0]  HoldMax   = HoldW'(DEAD_HOLD);
    localparam logic [2:0]        LevelMax  = 3'(MAX_LEVEL);

    game_state_e       state_d, state_q;
    logic              start_prev_q;
    logic              start_edge;
    logic [FrameW-1:0] frame_cnt_d, frame_cnt_q;
    logic [LvlW-1:0]   lvl_cnt_d, lvl_cnt_q;
    logic [2:0]        level_d, level_q;
    logic [HoldW-1:0]  hold_cnt_d, hold_cnt_q;
    logic [ScoreW-1:0] hi_d, hi_q;
    logic              new_hi_d, new_hi_q;
    logic              score_tick_q;
    logic [ScoreW-1:0] score;
    logic              point_due, restart, enter_dead;

    assign start_edge = start_btn & ~start_prev_q;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= GsIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; start is only honoured in DEAD once the hold window has elapsed.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            GsIdle:  if (start_edge) state_d = GsRun;
            GsRun:   if (collision) state_d = GsDead;
            GsDead:  if (start_edge && hold_cnt_q == HoldMax) state_d = GsRun;
            default: state_d = GsIdle;
        endcase
    end

    // Control decode; collision suppresses a point due in the same cycle.
    always_comb begin
        point_due  = (state_q == GsRun) && frame_tick && !collision && (frame_cnt_q == FrameLast);
        enter_dead = (state_q == GsRun) && collision;
        restart    = (state_q == GsDead) && (state_d == GsRun);
    end

    // Datapath next-state: frame/point/level counters, dead-hold timer, high score.
    always_comb begin
        frame_cnt_d = frame_cnt_q;
        lvl_cnt_d   = lvl_cnt_q;
        level_d     = level_q;
        hold_cnt_d  = hold_cnt_q;
        hi_d        = hi_q;
        new_hi_d    = new_hi_q;

        if (state_q != GsRun) begin
            frame_cnt_d = '0;
        end else if (frame_tick && !collision) begin
            frame_cnt_d = point_due ? '0 : frame_cnt_q + 1'b1;
        end

        if (restart) begin
            lvl_cnt_d = '0;
            level_d   = '0;
            new_hi_d  = 1'b0;
        end else if (point_due) begin
            if (lvl_cnt_q == LvlLast) begin
                lvl_cnt_d = '0;
                if (level_q < LevelMax) level_d = level_q + 3'd1;
            end else begin
                lvl_cnt_d = lvl_cnt_q + 1'b1;
            end
        end

        if (enter_dead) begin
            hold_cnt_d = '0;
            // Plain binary compare orders packed BCD correctly.
            if (score > hi_q) begin
                hi_d     = score;
                new_hi_d = 1'b1;
            end else begin
                new_hi_d = 1'b0;
            end
        end else if (state_q == GsDead && frame_tick && hold_cnt_q < HoldMax) begin
            hold_cnt_d = hold_cnt_q + 1'b1;
        end
    end

    // Datapath registers; score_tick is the registered point strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_prev_q <= 1'b0;
            frame_cnt_q  <= '0;
            lvl_cnt_q    <= '0;
            level_q      <= '0;
            hold_cnt_q   <= '0;
            hi_q         <= '0;
            new_hi_q     <= 1'b0;
            score_tick_q <= 1'b0;
        end else begin
            start_prev_q <= start_btn;
            frame_cnt_q  <= frame_cnt_d;
            lvl_cnt_q    <= lvl_cnt_d;
            level_q      <= level_d;
            hold_cnt_q   <= hold_cnt_d;
            hi_q         <= hi_d;
            new_hi_q     <= new_hi_d;
            score_tick_q <= point_due;
        end
    end

    bcd4_counter u_score (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .clr_i   (restart),
        .inc_i   (point_due),
        .count_o (score)
    );

    assign gameState   = state_q;
    assign score_tick  = score_tick_q;
    assign score_bcd   = score;
    assign hi_bcd      = hi_q;
    assign speed_level = level_q;
    assign new_hi      = new_hi_q;

endmodule

// File: tb/tb_score_run_controller.sv
// Self-checking bench for score_run_controller: vector table, directed corners, random vs model.
module tb_score_run_controller;

    localparam int T  = 6;
    localparam int P  = 100;
    localparam int ML = 7;
    localparam int DH = 60;

    localparam int MIdle = 0;
    localparam int MRun  = 1;
    localparam int MDead = 2;

    logic        clk = 1'b0;
    logic        rst_n, frame_tick, start_btn, collision;
    logic [1:0]  game_state;
    logic        score_tick, new_hi;
    logic [15:0] score_bcd, hi_bcd;
    logic [2:0]  speed_level;

    logic        f_ft, f_sb, f_col;
    logic [1:0]  f_state;
    logic        f_tick, f_new_hi;
    logic [15:0] f_score, f_hi;
    logic [2:0]  f_lvl;

    always #5 clk = ~clk;

    score_run_controller dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_tick  (frame_tick),
        .start_btn   (start_btn),
        .collision   (collision),
        .gameState   (game_state),
        .score_tick  (score_tick),
        .score_bcd   (score_bcd),
        .hi_bcd      (hi_bcd),
        .speed_level (speed_level),
        .new_hi      (new_hi)
    );

    // One point per frame so the 9999 -> 0000 wrap is reachable in a short run.
    score_run_controller #(
        .TICKS_PER_POINT  (1),
        .POINTS_PER_LEVEL (1000),
        .MAX_LEVEL        (7),
        .DEAD_HOLD        (60)
    ) dut_fast (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_tick  (f_ft),
        .start_btn   (f_sb),
        .collision   (f_col),
        .gameState   (f_state),
        .score_tick  (f_tick),
        .score_bcd   (f_score),
        .hi_bcd      (f_hi),
        .speed_level (f_lvl),
        .new_hi      (f_new_hi)
    );

    int n_vec  = 0;
    int n_fail = 0;

    // Reference model state, kept as plain integers.
    int m_state, m_score, m_hi, m_lvl, m_frames, m_pts, m_hold;
    bit m_tick, m_new_hi, m_prev;

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    function automatic logic [1:0] enc_state(input int s);
        if (s == MRun) return 2'b10;
        if (s == MDead) return 2'b01;
        return 2'b00;
    endfunction

    task automatic model_reset();
        m_state = MIdle; m_score = 0; m_hi = 0; m_lvl = 0;
        m_frames = 0; m_pts = 0; m_hold = 0;
        m_tick = 0; m_new_hi = 0; m_prev = 0;
    endtask

    task automatic model_step(input bit ft, input bit sb, input bit col);
        bit edge_s, go;
        edge_s = sb && !m_prev;
        m_prev = sb;
        m_tick = 0;
        case (m_state)
            MIdle: if (edge_s) m_state = MRun;
            MRun: begin
                if (col) begin
                    m_state = MDead;
                    m_hold  = 0;
                    if (m_score > m_hi) begin
                        m_hi = m_score;
                        m_new_hi = 1;
                    end else begin
                        m_new_hi = 0;
                    end
                end else if (ft) begin
                    m_frames++;
                    if (m_frames == T) begin
                        m_frames = 0;
                        m_tick   = 1;
                        m_score  = (m_score + 1) % 10000;
                        m_pts++;
                        if (m_pts == P) begin
                            m_pts = 0;
                            if (m_lvl < ML) m_lvl++;
                        end
                    end
                end
            end
            default: begin
                go = edge_s && (m_hold >= DH);
                if (ft && m_hold < DH) m_hold++;
                if (go) begin
                    m_state = MRun; m_score = 0; m_lvl = 0;
                    m_frames = 0; m_pts = 0; m_new_hi = 0;
                end
            end
        endcase
    endtask

    function automatic logic [38:0] dut_vec();
        return {game_state, score_tick, score_bcd, hi_bcd, speed_level, new_hi};
    endfunction

    function automatic logic [38:0] model_vec();
        return {enc_state(m_state), m_tick, to_bcd(m_score), to_bcd(m_hi), 3'(m_lvl), m_new_hi};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive inputs, take one clock, advance the model, compare after the edge.
    task automatic cycle(input bit ft, input bit sb, input bit col);
        frame_tick = ft;
        start_btn  = sb;
        collision  = col;
        @(posedge clk);
        model_step(ft, sb, col);
        #1;
        check("model", 64'(dut_vec()), 64'(model_vec()));
    endtask

    typedef struct {
        bit          ft, sb, col;
        logic [1:0]  st;
        bit          tick;
        logic [15:0] score, hi;
        bit          nh;
    } vec_t;

    vec_t tbl[12];

    initial begin
        // First run: start, six frames to one point, ignored start, collision.
        tbl[0]  = '{0, 0, 0, 2'b00, 0, 16'h0000, 16'h0000, 0};
        tbl[1]  = '{0, 1, 0, 2'b10, 0, 16'h0000, 16'h0000, 0};
        tbl[2]  = '{1, 1, 0, 2'b10, 0, 16'h0000, 16'h0000, 0};
        tbl[3]  = '{1, 1, 0, 2'b10, 0, 16'h0000, 16'h0000, 0};
        tbl[4]  = '{1, 1, 0, 2'b10, 0, 16'h0000, 16'h0000, 0};
        tbl[5]  = '{1, 1, 0, 2'b10, 0, 16'h0000, 16'h0000, 0};
        tbl[6]  = '{1, 1, 0, 2'b10, 0, 16'h0000, 16'h0000, 0};
        tbl[7]  = '{1, 1, 0, 2'b10, 1, 16'h0001, 16'h0000, 0};
        tbl[8]  = '{0, 0, 0, 2'b10, 0, 16'h0001, 16'h0000, 0};
        tbl[9]  = '{0, 1, 0, 2'b10, 0, 16'h0001, 16'h0000, 0};
        tbl[10] = '{1, 1, 1, 2'b01, 0, 16'h0001, 16'h0001, 1};
        tbl[11] = '{0, 0, 0, 2'b01, 0, 16'h0001, 16'h0001, 1};

        rst_n = 1'b0; frame_tick = 0; start_btn = 0; collision = 0;
        f_ft = 0; f_sb = 0; f_col = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset", 64'(dut_vec()), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            cycle(tbl[i].ft, tbl[i].sb, tbl[i].col);
            check($sformatf("table[%0d]", i),
                  64'({game_state, score_tick, score_bcd, hi_bcd, new_hi}),
                  64'({tbl[i].st, tbl[i].tick, tbl[i].score, tbl[i].hi, tbl[i].nh}));
        end

        // Start during the hold window is ignored; after DEAD_HOLD frames it restarts.
        repeat (10) cycle(1, 0, 0);
        cycle(0, 1, 0);
        check("dead_hold_early_state", 64'(game_state), 64'(2'b01));
        cycle(0, 0, 0);
        repeat (50) cycle(1, 0, 0);
        cycle(0, 1, 0);
        check("restart_state_score_newhi", 64'({game_state, score_bcd, new_hi}),
              64'({2'b10, 16'h0000, 1'b0}));

        // Level increments and saturation.
        repeat (600) cycle(1, 0, 0);
        check("lvl1_score_level", 64'({score_bcd, speed_level}), 64'({16'h0100, 3'd1}));
        repeat (3600) cycle(1, 0, 0);
        check("lvl7_reached", 64'({score_bcd, speed_level}), 64'({16'h0700, 3'd7}));
        repeat (600) cycle(1, 0, 0);
        check("lvl7_saturated", 64'({score_bcd, speed_level}), 64'({16'h0800, 3'd7}));

        // Asynchronous reset mid-run, observed before the next clock edge.
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_reset", 64'(dut_vec()), 64'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        cycle(0, 0, 0);

        // Start held high through the run; collision on the point-due frame drops the point.
        cycle(0, 1, 0);
        repeat (252) cycle(1, 1, 0);
        check("score_42", 64'(score_bcd), 64'(16'h0042));
        repeat (5) cycle(1, 1, 0);
        cycle(1, 1, 1);
        check("collision_drop", 64'({game_state, score_tick, score_bcd, hi_bcd, new_hi}),
              64'({2'b01, 1'b0, 16'h0042, 16'h0042, 1'b1}));
        cycle(0, 0, 0);
        repeat (60) cycle(1, 0, 0);
        cycle(0, 1, 0);
        repeat (60) cycle(1, 0, 0);
        cycle(0, 0, 1);
        check("lower_run_keeps_hi", 64'({game_state, score_bcd, hi_bcd, new_hi}),
              64'({2'b01, 16'h0010, 16'h0042, 1'b0}));

        // Randomised play against the model.
        for (int i = 0; i < 3000; i++) begin
            bit ft, col;
            ft  = ($urandom_range(0, 1) == 1);
            col = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 7) == 0) start_btn = ~start_btn;
            cycle(ft, start_btn, col);
        end

        // Four-digit wrap on the one-frame-per-point instance.
        f_sb = 1; f_ft = 1;
        @(posedge clk);
        #1;
        check("fast_start", 64'(f_state), 64'(2'b10));
        repeat (9999) @(posedge clk);
        #1;
        check("fast_9999", 64'({f_score, f_tick}), 64'({16'h9999, 1'b1}));
        @(posedge clk);
        #1;
        check("fast_wrap", 64'({f_state, f_score, f_tick}), 64'({2'b10, 16'h0000, 1'b1}));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
